// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed 4-digit seven-segment bus: waits for each
// digit slot to settle, decodes the segment pattern and rebuilds the displayed word.

module seg_scan_lane (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cap,
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_err
);
  logic [6:0] w_lit;
  logic [3:0] w_val;
  logic       w_ok;
  logic [3:0] r_digit;
  logic       r_err;

  assign w_lit = ~i_seg;

  always_comb begin
    w_ok  = 1'b1;
    w_val = 4'h0;
    case (w_lit)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_ok = 1'b0;
    endcase
  end

  // An undecodable pattern keeps the last good value and only flags the error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= 4'h0;
      r_err   <= 1'b0;
    end else if (i_cap) begin
      r_err <= ~w_ok;
      if (w_ok) r_digit <= w_val;
    end
  end

  assign o_digit = r_digit;
  assign o_err   = r_err;
endmodule

module seg_scan_decoder #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_an,
  input  logic [6:0]  i_seg,
  output logic [15:0] o_digits,
  output logic [3:0]  o_digit_err,
  output logic        o_frame_valid,
  output logic        o_stale
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } smp_t;

  smp_t                             r_s1, r_s2, r_prev;
  logic [CW-1:0]                    r_cnt;
  logic [TW-1:0]                    r_tcnt;
  logic [NUM_DIGITS-1:0]            r_seen;
  logic                             r_fv;
  logic                             r_stale;
  logic [NUM_DIGITS-1:0]            w_sel;
  logic                             w_one;
  logic                             w_cap_any;
  logic [NUM_DIGITS-1:0]            w_cap;
  logic [NUM_DIGITS-1:0]            w_seen_nxt;
  logic [TW-1:0]                    w_tcnt_nxt;
  logic                             w_to;
  logic [NUM_DIGITS-1:0][3:0]       w_digits;
  logic [NUM_DIGITS-1:0]            w_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= '1;
      r_s2   <= '1;
      r_prev <= '1;
    end else begin
      r_s1   <= '{an: i_an, seg: i_seg};
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Counter saturates so a slot held forever captures exactly once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (r_s2 != r_prev)       r_cnt <= '0;
    else if (r_cnt != CW'(SETTLE)) r_cnt <= r_cnt + CW'(1);
  end

  assign w_sel      = ~r_s2.an;
  assign w_one      = (w_sel != '0) && ((w_sel & (w_sel - 4'd1)) == '0);
  assign w_cap_any  = (r_s2 == r_prev) && (r_cnt == CW'(SETTLE - 1)) && w_one;
  assign w_cap      = w_cap_any ? w_sel : '0;
  assign w_seen_nxt = r_seen | w_cap;
  assign w_tcnt_nxt = w_cap_any ? '0 :
                      (r_tcnt == TW'(TIMEOUT)) ? r_tcnt : r_tcnt + TW'(1);
  assign w_to       = !w_cap_any && (w_tcnt_nxt == TW'(TIMEOUT));

  // A capture on the same edge as the timeout wins: stale stays low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
      r_seen  <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_fv   <= 1'b0;
      if (w_cap_any) begin
        r_stale <= 1'b0;
        if (&w_seen_nxt) begin
          r_seen <= '0;
          r_fv   <= 1'b1;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end else if (w_to) begin
        r_stale <= 1'b1;
        r_seen  <= '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg_scan_lane u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_cap   (w_cap[g]),
      .i_seg   (r_s2.seg),
      .o_digit (w_digits[g]),
      .o_err   (w_err[g])
    );
  end

  assign o_digits      = w_digits;
  assign o_digit_err   = w_err;
  assign o_frame_valid = r_fv;
  assign o_stale       = r_stale;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE=4, TIMEOUT=64; inputs change
// and outputs are observed on falling edges.

module tb_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fv_cnt  = 0;
  int          fv_base;

  // Active-high gfedcba for 0..F
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_decoder #(.SETTLE(4), .TIMEOUT(64)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_an          (an),
    .i_seg         (seg),
    .o_digits      (digits),
    .o_digit_err   (digit_err),
    .o_frame_valid (frame_valid),
    .o_stale       (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int d, input int v);
    an  = ~(4'b0001 << d);
    seg = ~pat[v];
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    wait_n(3);
    chk("reset_digits", digits, 16'h0);
    chk("reset_err", digit_err, 4'h0);
    chk("reset_fv", frame_valid, 1'b0);
    chk("reset_stale", stale, 1'b0);
    rst_n = 1'b1;

    // Scan 1,2,3,4 into digits 0..3
    for (int d = 0; d < 3; d++) begin
      drive(d, d + 1);
      wait_n(20);
    end
    fv_base = fv_cnt;
    drive(3, 4);
    wait_n(6);
    chk("frame_early", frame_valid, 1'b0);
    wait_n(1);
    chk("frame_pulse", frame_valid, 1'b1);
    chk("scan_digits", digits, 16'h4321);
    chk("scan_err", digit_err, 4'h0);
    wait_n(1);
    chk("frame_one_cycle", frame_valid, 1'b0);
    wait_n(12);
    chk("frame_count", fv_cnt - fv_base, 1);

    // Digit 2: all-on 8, then invalid 'a only', then valid E
    an = 4'b1011; seg = 7'b0000000;
    wait_n(7);
    chk("d2_eight", digits[11:8], 4'h8);
    chk("d2_err0", digit_err, 4'h0);
    wait_n(13);
    seg = 7'b1111110;
    wait_n(7);
    chk("d2_invalid_keep", digits[11:8], 4'h8);
    chk("d2_invalid_err", digit_err, 4'b0100);
    wait_n(13);
    drive(2, 14);
    wait_n(7);
    chk("d2_valid_val", digits[11:8], 4'hE);
    chk("d2_valid_clr", digit_err, 4'h0);
    wait_n(13);

    // Slot 1 glitching every 3 clocks, then stable A
    for (int k = 0; k < 10; k++) begin
      drive(1, (k % 2) ? 6 : 5);
      wait_n(3);
    end
    chk("glitch_nocap", digits[7:4], 4'h2);
    drive(1, 10);
    wait_n(6);
    chk("glitch_settle_early", digits[7:4], 4'h2);
    wait_n(1);
    chk("glitch_settle_A", digits[7:4], 4'hA);

    // Blank bus straight after the capture edge
    fv_base = fv_cnt;
    an = 4'hF;
    wait_n(63);
    chk("stale_early", stale, 1'b0);
    wait_n(1);
    chk("stale_at_64", stale, 1'b1);
    wait_n(36);
    chk("blank_stale_hold", stale, 1'b1);
    chk("blank_digits", digits, 16'h4EA1);
    chk("blank_no_frame", fv_cnt - fv_base, 0);
    drive(0, 0);
    wait_n(6);
    chk("stale_before_cap", stale, 1'b1);
    wait_n(1);
    chk("stale_cleared", stale, 1'b0);
    chk("cap_after_stale", digits, 16'h4EA0);

    // Multi-low anode is ignored
    an = 4'b0011; seg = ~pat[7];
    wait_n(20);
    chk("multi_digits", digits, 16'h4EA0);
    chk("multi_err", digit_err, 4'h0);
    chk("multi_no_frame", fv_cnt - fv_base, 0);

    // Three digits, then reset mid-frame
    for (int d = 0; d < 3; d++) begin
      drive(d, d + 5);
      wait_n(10);
    end
    chk("pre_reset_digits", digits, 16'h4765);
    rst_n = 1'b0;
    #1;
    chk("midreset_digits", digits, 16'h0);
    chk("midreset_err", digit_err, 4'h0);
    chk("midreset_fv", frame_valid, 1'b0);
    chk("midreset_stale", stale, 1'b0);
    an = 4'hF; seg = 7'h7F;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(2);
    fv_base = fv_cnt;
    drive(3, 9);
    wait_n(7);
    chk("post_reset_d3", digits, 16'h9000);
    wait_n(13);
    chk("post_reset_no_frame", fv_cnt - fv_base, 0);
    drive(0, 1);
    wait_n(20);
    drive(1, 2);
    wait_n(20);
    chk("rescan_no_frame_yet", fv_cnt - fv_base, 0);
    drive(2, 3);
    wait_n(6);
    chk("rescan_fv_early", frame_valid, 1'b0);
    wait_n(1);
    chk("rescan_fv", frame_valid, 1'b1);
    chk("rescan_digits", digits, 16'h9321);
    wait_n(5);
    chk("rescan_frame_count", fv_cnt - fv_base, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
